// File: rtl/sequence_timer.sv
// One-hot phase sequencer for the control unit: advances T each clock, with
// memory stall, instruction-boundary halt/step/resume, stall watchdog and debug counter.
module sequence_timer #(
  parameter int PHASES   = 8,
  parameter int ICNT_W   = 16,
  parameter int WDOG_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seq_counter_RESET,
  input  logic              mem_wait,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              step,
  input  logic              clear_flags,
  output logic [PHASES-1:0] T,
  output logic              running,
  output logic              halted,
  output logic [ICNT_W-1:0] instr_count,
  output logic              wdog_timeout,
  output logic              seq_overrun
);

  localparam int WD_W = $clog2(WDOG_MAX + 1);
  localparam logic [PHASES-1:0] T0 = PHASES'(1);

  typedef enum logic [1:0] {RUN, STEP, HALTED} state_t;

  state_t            state, state_n;
  logic [PHASES-1:0] t_n;
  logic [ICNT_W-1:0] icnt_n;
  logic [WD_W-1:0]   wd_cnt, wd_n;
  logic              wdto_set, ovr_set, boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      T            <= T0;
      instr_count  <= '0;
      wd_cnt       <= '0;
      wdog_timeout <= 1'b0;
      seq_overrun  <= 1'b0;
    end else begin
      state        <= state_n;
      T            <= t_n;
      instr_count  <= icnt_n;
      wd_cnt       <= wd_n;
      // a set on the same edge as a clear takes precedence
      wdog_timeout <= wdto_set | (wdog_timeout & ~clear_flags);
      seq_overrun  <= ovr_set  | (seq_overrun  & ~clear_flags);
    end
  end

  always_comb begin
    state_n  = state;
    t_n      = T;
    icnt_n   = instr_count;
    wd_n     = wd_cnt;
    wdto_set = 1'b0;
    ovr_set  = 1'b0;
    boundary = 1'b0;
    case (state)
      HALTED: begin
        t_n = T0;
        if (resume)    state_n = RUN;
        else if (step) state_n = STEP;
      end
      default: begin
        if (seq_counter_RESET) begin
          t_n      = T0;
          icnt_n   = instr_count + ICNT_W'(1);
          wd_n     = '0;
          boundary = 1'b1;
        end else if (mem_wait) begin
          if (wd_cnt == WD_W'(WDOG_MAX - 1)) begin
            // abandon the stalled instruction without counting it
            t_n      = T0;
            wd_n     = '0;
            wdto_set = 1'b1;
            boundary = 1'b1;
          end else begin
            wd_n = wd_cnt + WD_W'(1);
          end
        end else begin
          t_n  = {T[PHASES-2:0], T[PHASES-1]};
          wd_n = '0;
          if (T[PHASES-1]) begin
            ovr_set  = 1'b1;
            icnt_n   = instr_count + ICNT_W'(1);
            boundary = 1'b1;
          end
        end
        if (boundary && (halt_req || state == STEP)) state_n = HALTED;
      end
    endcase
  end

  assign running = (state == RUN) || (state == STEP);
  assign halted  = (state == HALTED);

endmodule

// File: tb/tb_sequence_timer.sv
// Bench for sequence_timer: directed vector table, hand-written halt/step and
// async-reset sequences, then random stimulus against a phase-index model.
module tb_sequence_timer;
  localparam int PH = 8, IW = 4, WD = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sr = 0, mw = 0, hr = 0, rs = 0, st = 0, cl = 0;
  logic [PH-1:0] T;
  logic running, halted, wdog_timeout, seq_overrun;
  logic [IW-1:0] instr_count;

  int checks = 0, errors = 0;

  sequence_timer #(.PHASES(PH), .ICNT_W(IW), .WDOG_MAX(WD)) dut (
    .clk(clk), .rst_n(rst_n), .seq_counter_RESET(sr), .mem_wait(mw),
    .halt_req(hr), .resume(rs), .step(st), .clear_flags(cl),
    .T(T), .running(running), .halted(halted), .instr_count(instr_count),
    .wdog_timeout(wdog_timeout), .seq_overrun(seq_overrun));

  always #5 clk = ~clk;

  typedef struct {
    bit sr, mw, hr, rs, st, cl;
    logic [7:0] t; bit hlt; logic [3:0] cnt; bit wd, ov;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(bit a, b, c, d, e, f, logic [7:0] t, bit h,
                              logic [3:0] n, bit w, bit o);
    vec_t v;
    v.sr = a; v.mw = b; v.hr = c; v.rs = d; v.st = e; v.cl = f;
    v.t = t; v.hlt = h; v.cnt = n; v.wd = w; v.ov = o;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit a, b, c, d, e, f);
    sr = a; mw = b; hr = c; rs = d; st = e; cl = f;
    @(posedge clk); #1;
  endtask

  task automatic check_all(input string nm, input logic [7:0] t, input bit h,
                           input logic [3:0] n, input bit w, input bit o);
    check({nm, ".T"}, T, t);
    check({nm, ".halted"}, halted, h);
    check({nm, ".running"}, running, !h);
    check({nm, ".cnt"}, instr_count, n);
    check({nm, ".wdog"}, wdog_timeout, w);
    check({nm, ".ovr"}, seq_overrun, o);
  endtask

  // reference model: phase index, mode (0 run, 1 step, 2 halted)
  int m_ph, m_mode, m_cnt, m_stall;
  bit m_wd, m_ov;

  task automatic model_reset();
    m_ph = 0; m_mode = 0; m_cnt = 0; m_stall = 0; m_wd = 0; m_ov = 0;
  endtask

  task automatic model_edge(input bit a, b, c, d, e, f);
    bit bnd = 0, wset = 0, oset = 0;
    if (m_mode == 2) begin
      if (d) m_mode = 0;
      else if (e) m_mode = 1;
    end else begin
      if (a) begin
        m_ph = 0; m_cnt = (m_cnt + 1) % (1 << IW); m_stall = 0; bnd = 1;
      end else if (b) begin
        m_stall++;
        if (m_stall == WD) begin m_ph = 0; m_stall = 0; wset = 1; bnd = 1; end
      end else begin
        m_stall = 0;
        if (m_ph == PH - 1) begin
          m_ph = 0; oset = 1; m_cnt = (m_cnt + 1) % (1 << IW); bnd = 1;
        end else m_ph++;
      end
      if (bnd && (c || m_mode == 1)) m_mode = 2;
    end
    m_wd = wset | (m_wd & !f);
    m_ov = oset | (m_ov & !f);
  endtask

  initial begin
    // reset / free run to T7, boundary from the control unit
    for (int i = 1; i < 8; i++) vecs.push_back(mk(0,0,0,0,0,0, 8'(1 << i), 0, 0, 0, 0));
    vecs.push_back(mk(1,0,0,0,0,0, 8'h01, 0, 1, 0, 0));
    // three-cycle stall at T4
    for (int i = 1; i < 5; i++) vecs.push_back(mk(0,0,0,0,0,0, 8'(1 << i), 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,0,0,0,0, 8'h10, 0, 1, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h20, 0, 1, 0, 0));
    vecs.push_back(mk(1,0,0,0,0,0, 8'h01, 0, 2, 0, 0));
    // watchdog fires on the 4th stalled edge at T3, then clear
    for (int i = 1; i < 4; i++) vecs.push_back(mk(0,0,0,0,0,0, 8'(1 << i), 0, 2, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,0,0,0,0, 8'h08, 0, 2, 0, 0));
    vecs.push_back(mk(0,1,0,0,0,0, 8'h01, 0, 2, 1, 0));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h02, 0, 2, 0, 0));
    vecs.push_back(mk(1,0,0,0,0,0, 8'h01, 0, 3, 0, 0));
    // overrun wrap, clear, then set+clear on the same edge
    for (int i = 1; i < 8; i++) vecs.push_back(mk(0,0,0,0,0,0, 8'(1 << i), 0, 3, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,0, 8'h01, 0, 4, 0, 1));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h02, 0, 4, 0, 0));
    for (int i = 2; i < 8; i++) vecs.push_back(mk(0,0,0,0,0,0, 8'(1 << i), 0, 4, 0, 0));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h01, 0, 5, 0, 1));
    vecs.push_back(mk(0,0,0,0,0,1, 8'h02, 0, 5, 0, 0));
    vecs.push_back(mk(1,0,0,0,0,0, 8'h01, 0, 6, 0, 0));

    #12;
    check_all("reset", 8'h01, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1; #4;

    foreach (vecs[i]) begin
      drive(vecs[i].sr, vecs[i].mw, vecs[i].hr, vecs[i].rs, vecs[i].st, vecs[i].cl);
      check_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].hlt, vecs[i].cnt, vecs[i].wd, vecs[i].ov);
    end

    // halt request mid-instruction, then ignored inputs while halted
    drive(0,0,0,0,0,0); drive(0,0,1,0,0,0);
    check_all("pre_halt", 8'h04, 0, 6, 0, 0);
    drive(1,0,1,0,0,0);
    check_all("halt", 8'h01, 1, 7, 0, 0);
    for (int i = 0; i < 10; i++) drive(i[0], i[1], 1, 0, 0, 0);
    check_all("halt_hold", 8'h01, 1, 7, 0, 0);
    // single step: one instruction then re-halt
    drive(0,0,0,0,1,0);
    check_all("step_leave", 8'h01, 0, 7, 0, 0);
    drive(0,0,0,0,0,0); drive(0,0,0,0,0,0);
    check_all("step_run", 8'h04, 0, 7, 0, 0);
    drive(1,0,0,0,0,0);
    check_all("step_rehalt", 8'h01, 1, 8, 0, 0);
    // resume wins over step: boundary afterwards must not halt
    drive(0,0,0,1,1,0);
    drive(0,0,0,0,0,0);
    check_all("resume_t1", 8'h02, 0, 8, 0, 0);
    drive(1,0,0,0,0,0);
    check_all("resume_run", 8'h01, 0, 9, 0, 0);
    // count wrap at 2^4
    for (int i = 0; i < 7; i++) drive(1,0,0,0,0,0);
    check_all("cnt_zero", 8'h01, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) drive(1,0,0,0,0,0);
    check_all("cnt_wrap", 8'h01, 0, 0, 0, 0);

    // async reset mid-stall with halt pending and a sticky flag set
    for (int i = 0; i < 4; i++) drive(0,1,0,0,0,0);
    drive(0,0,0,0,0,0); drive(0,0,0,0,0,0);
    drive(0,1,1,0,0,0); drive(0,1,1,0,0,0);
    check_all("pre_arst", 8'h04, 0, 0, 1, 0);
    #2 rst_n = 1'b0; #1;
    check_all("arst", 8'h01, 0, 0, 0, 0);
    sr = 0; mw = 0; hr = 0; rs = 0; st = 0; cl = 0;
    @(negedge clk); rst_n = 1'b1; #4;

    // random stimulus against the model
    model_reset();
    for (int i = 0; i < 600; i++) begin
      bit a, b, c, d, e, f;
      a = ($urandom_range(99) < 15); b = ($urandom_range(99) < 40);
      c = ($urandom_range(99) < 15); d = ($urandom_range(99) < 10);
      e = ($urandom_range(99) < 12); f = ($urandom_range(99) < 8);
      model_edge(a, b, c, d, e, f);
      drive(a, b, c, d, e, f);
      check_all($sformatf("rnd%0d", i), 8'(1 << m_ph), m_mode == 2, 4'(m_cnt), m_wd, m_ov);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sequence_timer.md
# sequence_timer

Generates the one-hot timing sequence `T[7:0]` that drives the control unit's per-phase micro-operations. It advances one phase per clock and returns to T0 when the control unit raises `seq_counter_RESET` at the end of an instruction. It also provides:
- memory wait-state stalling;
- halt / resume / single-step at instruction boundaries;
- a stall watchdog;
- an instruction counter for debug.

## Interface
Parameters:
- `PHASES`, 8, number of timing phases (width of `T`); ≥ 4
- `ICNT_W`, 16, width of the instruction counter
- `WDOG_MAX`, 255, consecutive `mem_wait` cycles tolerated before the watchdog fires; ≥ 1

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `seq_counter_RESET`  in  1  end-of-instruction request from the control unit; sequence returns to T0
- `mem_wait`  in  1  memory not ready; hold the current phase
- `halt_req`  in  1  level; halt at the next instruction boundary
- `resume`  in  1  pulse; leave HALTED and free-run
- `step`  in  1  pulse; leave HALTED, execute one instruction, re-halt
- `clear_flags`  in  1  clears the sticky flags
- `T`  out  PHASES  one-hot phase vector
- `running`  out  1  high in RUN or STEP
- `halted`  out  1  high in HALTED
- `instr_count`  out  ICNT_W  completed instructions; wraps modulo 2^ICNT_W
- `wdog_timeout`  out  1  sticky; watchdog fired
- `seq_overrun`  out  1  sticky; `T` wrapped past the last phase without `seq_counter_RESET`

## Operation
- Reset values:
  - `T` = 1 (T0)
  - state = RUN, `running` = 1, `halted` = 0
  - `instr_count` = 0
  - `wdog_timeout` = 0, `seq_overrun` = 0
  - watchdog counter = 0
- States: RUN, STEP, HALTED. `T` is exactly one-hot in every cycle, including after reset.

Each clock in RUN or STEP takes the first matching action, in this priority order:
1. **`seq_counter_RESET` = 1** (instruction boundary):
   - `T` ← T0; `instr_count` += 1; watchdog counter ← 0.
   - Next state:
     - if `halt_req` = 1 or state = STEP: HALTED;
     - else stay in the current state.
2. **`mem_wait` = 1:**
   - `T` holds; watchdog counter += 1.
   - If the counter reaches `WDOG_MAX` on this edge:
     - `T` ← T0; counter ← 0; `wdog_timeout` ← 1.
     - `instr_count` does not increment.
     - Halt rules are the same as at a boundary.
3. **Otherwise:**
   - `T` rotates left one position; watchdog counter ← 0.
   - If `T` was T[PHASES-1]: it wraps to T0, `seq_overrun` ← 1, `instr_count` += 1, and halt rules apply as at a boundary.

HALTED:
- `T` held at T0; `instr_count` and watchdog frozen.
- `mem_wait`, `seq_counter_RESET` and `halt_req` are ignored.
- `resume` → RUN. `step` → STEP. Both high together → RUN (`resume` wins).

Other rules:
- `clear_flags` clears both sticky flags. If a flag is set and cleared on the same edge, the set wins.
- `halt_req` sampled in STEP has no extra effect; STEP always re-halts at the next boundary.
- Asserting `rst_n` mid-instruction forces the reset values immediately, regardless of state.

## Timing
- Every output is registered, with one-cycle latency from the inputs.
  - A `seq_counter_RESET` sampled on edge N gives `T` = T0 after edge N.
- Instruction boundary to HALTED:
  - `halted` rises on the same edge that `T` returns to T0.
  - The control unit sees T0 held; it must tolerate idle T0 cycles (T0 is side-effect-free apart from reloading AR).
- `resume` / `step` sampled on edge N: `T` advances to T1 on edge N+1.
- The control unit raises `seq_counter_RESET` one cycle after the phase that requests it (it registers its outputs). For example, with the reset decoded in T6, the sequence runs T0…T6, then `seq_counter_RESET` is seen while `T` = T7, and `T` returns to T0.
  - With PHASES = 8 this sequence does not set `seq_overrun`.
- Watchdog fires on the `WDOG_MAX`-th consecutive stalled edge. A single non-stall cycle restarts the count.

## Test plan
- **Reset and free run:** release `rst_n` → `T` = 0x01, 0x02, 0x04 … 0x40; then `seq_counter_RESET` pulsed while `T` = 0x80 → `T` = 0x01 and `instr_count` = 1; `seq_overrun` stays 0.
- **Stall:** `mem_wait` high for 3 cycles while `T` = 0x10 → `T` stays 0x10 for 3 cycles, then advances to 0x20; `wdog_timeout` = 0.
- **Watchdog:** `WDOG_MAX` = 4; `mem_wait` held high while `T` = 0x08 → after 4 edges `T` = 0x01, `wdog_timeout` = 1 and `instr_count` unchanged; then `clear_flags` → `wdog_timeout` = 0.
- **Halt / step / resume:**
  - `halt_req` = 1 mid-instruction → `halted` = 1 at the next boundary with `T` = 0x01 held for 10 cycles, `seq_counter_RESET` pulses ignored.
  - `step` → exactly one instruction runs, `instr_count` += 1, re-halted.
  - `resume` together with `step` → RUN.
- **Overrun and count wrap:** no `seq_counter_RESET` for 8 cycles → `T` wraps 0x80 → 0x01 and `seq_overrun` = 1. With `ICNT_W` = 4, 16 boundaries → `instr_count` wraps to 0.
- **Async reset mid-stall while HALTED pending:** drop `rst_n` asynchronously → all outputs take their reset values before the next clock edge.
